// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder constants and the result serializer state type.
// Imported by the decoder interface and by the hard-decision serializer.
package ldpc_pkg;

  localparam int R     = 24;
  localparam int D     = 96;
  localparam int DIM   = R * D;
  localparam int OUT_W = 16;
  localparam int WORDS = DIM / OUT_W;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } ser_state_e;

endpackage

// File: rtl/ldpc_res_ser_popcnt.sv
// Combinational population count of one output word.
// Feeds the bit-error accumulator of the serializer.
module popcnt #(
  parameter int OUT_W = 16
) (
  input  logic [OUT_W-1:0]       din_i,
  output logic [$clog2(OUT_W):0] cnt_o
);

  localparam int CW = $clog2(OUT_W) + 1;

  // Sum of the set bits of the word.
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < OUT_W; i++) begin
      cnt_o = cnt_o + CW'(din_i[i]);
    end
  end

endmodule

// File: rtl/ldpc_res_ser.sv
// Hard-decision frame serializer with error statistics.
// Captures one DIM-bit frame and streams it MSB-first in OUT_W-bit words.
module ldpc_res_ser #(
  parameter int R     = ldpc_pkg::R,
  parameter int D     = ldpc_pkg::D,
  parameter int OUT_W = ldpc_pkg::OUT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [R*D-1:0]     res,
  input  logic               res_valid,
  output logic               res_ready,
  output logic [OUT_W-1:0]   dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               dout_last,
  input  logic               stat_clr,
  output logic [31:0]        bit_err_cnt,
  output logic [15:0]        frm_err_cnt,
  output logic [15:0]        frm_cnt
);

  import ldpc_pkg::*;

  localparam int DIM   = R * D;
  localparam int WORDS = DIM / OUT_W;
  localparam int IDX_W = $clog2(WORDS);
  localparam int PC_W  = $clog2(OUT_W) + 1;

  ser_state_e state_q, state_d;

  logic [DIM-1:0]   res_q;
  logic [IDX_W-1:0] idx_q;
  logic             flag_q;
  logic [31:0]      bit_err_q;
  logic [15:0]      frm_err_q;
  logic [15:0]      frm_q;

  logic             cap;
  logic             hs;
  logic             last_w;
  logic [DIM-1:0]   shifted;
  logic [OUT_W-1:0] word;
  logic [PC_W-1:0]  pc;
  logic [32:0]      bit_sum;

  assign last_w = (idx_q == IDX_W'(WORDS - 1));
  assign cap    = res_ready & res_valid;
  assign hs     = dout_valid & dout_ready;

  assign shifted = res_q << (idx_q * OUT_W);
  assign word    = shifted[DIM-1 -: OUT_W];

  assign dout      = dout_valid ? word : '0;
  assign dout_last = dout_valid & last_w;

  assign bit_sum = {1'b0, bit_err_q} + 33'(pc);

  assign bit_err_cnt = bit_err_q;
  assign frm_err_cnt = frm_err_q;
  assign frm_cnt     = frm_q;

  popcnt #(
    .OUT_W(OUT_W)
  ) u_popcnt (
    .din_i(word),
    .cnt_o(pc)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    res_ready  = 1'b0;
    dout_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        res_ready = 1'b1;
        if (res_valid) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        dout_valid = 1'b1;
        if (dout_ready && last_w) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shadow frame, word index and per-frame error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q  <= '0;
      idx_q  <= '0;
      flag_q <= 1'b0;
    end else if (cap) begin
      res_q  <= res;
      idx_q  <= '0;
      flag_q <= 1'b0;
    end else if (hs) begin
      idx_q  <= last_w ? '0 : idx_q + IDX_W'(1);
      flag_q <= flag_q | (|word);
    end
  end

  // Saturating statistics; a clear wins over a same-cycle handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_err_q <= '0;
      frm_err_q <= '0;
      frm_q     <= '0;
    end else if (stat_clr) begin
      bit_err_q <= '0;
      frm_err_q <= '0;
      frm_q     <= '0;
    end else if (hs) begin
      bit_err_q <= bit_sum[32] ? '1 : bit_sum[31:0];
      if (last_w) begin
        if (frm_q != 16'hFFFF) frm_q <= frm_q + 16'd1;
        if ((flag_q || (|word)) && frm_err_q != 16'hFFFF) begin
          frm_err_q <= frm_err_q + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ldpc_res_ser.sv
// Scoreboard bench for the hard-decision serializer.
// Expected words and counters come from a frame-level model.
module tb_ldpc_res_ser;

  import ldpc_pkg::*;

  localparam int W  = OUT_W;
  localparam int NW = WORDS;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [DIM-1:0] res;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   dout;
  logic           dout_valid;
  logic           dout_ready;
  logic           dout_last;
  logic           stat_clr;
  logic [31:0]    bit_err_cnt;
  logic [15:0]    frm_err_cnt;
  logic [15:0]    frm_cnt;

  int     checks = 0;
  int     errors = 0;
  int     ready_mode = 0;
  exp_t   q[$];
  longint m_bit = 0;
  int     m_frm = 0;
  int     m_ferr = 0;

  ldpc_res_ser dut (
    .clk        (clk),
    .rst        (rst),
    .res        (res),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .stat_clr   (stat_clr),
    .bit_err_cnt(bit_err_cnt),
    .frm_err_cnt(frm_err_cnt),
    .frm_cnt    (frm_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sink readiness: always, one cycle in three, or random.
  initial begin : rdy
    int n;
    n = 0;
    dout_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      n++;
      case (ready_mode)
        0:       dout_ready = 1'b1;
        1:       dout_ready = (n % 3 == 0);
        default: dout_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every presented word is compared with the queue head.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (dout_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_word", 64'(dout_valid), 64'd0);
        end else begin
          e = q[0];
          chk("dout", 64'(dout), 64'(e.data));
          chk("dout_last", 64'(dout_last), 64'(e.last));
          if (dout_ready === 1'b1) void'(q.pop_front());
        end
      end
    end
  end

  function automatic logic [DIM-1:0] rnd_vec(input int density);
    logic [DIM-1:0] v;
    v = '0;
    for (int i = 0; i < DIM; i++) begin
      if ($urandom_range(0, 99) < density) v[i] = 1'b1;
    end
    return v;
  endfunction

  task automatic send(input logic [DIM-1:0] v);
    int n;
    int pc;
    n = 0;
    while (res_ready !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    if (res_ready !== 1'b1) chk("res_ready_timeout", 64'(res_ready), 64'd1);
    res = v;
    res_valid = 1'b1;
    for (int k = 0; k < NW; k++) begin
      q.push_back('{data: v[DIM-1-k*W -: W], last: (k == NW - 1)});
    end
    pc = $countones(v);
    m_bit = (m_bit + pc > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_bit + pc;
    if (m_frm < 65535) m_frm++;
    if (v != '0 && m_ferr < 65535) m_ferr++;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input bit pulse);
    int n;
    n = 0;
    while ((q.size() != 0 || res_ready !== 1'b1) && n < 5000) begin
      if (pulse && res_ready === 1'b0 && n % 7 == 3) begin
        res = rnd_vec(50);
        res_valid = 1'b1;
      end
      tick();
      res_valid = 1'b0;
      n++;
    end
    chk({name, "_done"}, 64'(q.size() == 0 && res_ready === 1'b1), 64'd1);
  endtask

  task automatic check_cnt(input string name);
    chk({name, "_bit_err_cnt"}, 64'(bit_err_cnt), 64'(m_bit));
    chk({name, "_frm_cnt"}, 64'(frm_cnt), 64'(m_frm));
    chk({name, "_frm_err_cnt"}, 64'(frm_err_cnt), 64'(m_ferr));
  endtask

  initial begin : stim
    logic [DIM-1:0] v;
    int n;
    rst = 1'b1;
    res = '0;
    res_valid = 1'b0;
    stat_clr = 1'b0;
    tick();
    tick();
    chk("rst_res_ready", 64'(res_ready), 64'd1);
    chk("rst_dout_valid", 64'(dout_valid), 64'd0);
    chk("rst_dout_last", 64'(dout_last), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    check_cnt("rst");
    rst = 1'b0;
    tick();

    // All-zero frame with a permanently ready sink.
    ready_mode = 0;
    send('0);
    wait_done("zero", 1'b0);
    check_cnt("zero");

    // Sparse frame: first and last words carry the set bits.
    v = '0;
    v[DIM-1] = 1'b1;
    v[DIM-16] = 1'b1;
    v[0] = 1'b1;
    send(v);
    wait_done("sparse", 1'b0);
    check_cnt("sparse");

    // Stalling sink with ignored capture requests while streaming.
    ready_mode = 1;
    send(rnd_vec(30));
    wait_done("stall", 1'b1);
    check_cnt("stall");

    // Random frames under random back-pressure.
    ready_mode = 2;
    for (int f = 0; f < 4; f++) begin
      send(rnd_vec((f == 0) ? 1 : 50));
      wait_done("rand", 1'b1);
      check_cnt("rand");
    end

    // Reset in the middle of a frame.
    ready_mode = 0;
    send(rnd_vec(50));
    n = 0;
    while (q.size() > NW - 70 && n < 2000) begin
      tick();
      n++;
    end
    rst = 1'b1;
    #1;
    chk("midrst_dout_valid", 64'(dout_valid), 64'd0);
    chk("midrst_res_ready", 64'(res_ready), 64'd1);
    chk("midrst_dout_last", 64'(dout_last), 64'd0);
    chk("midrst_dout", 64'(dout), 64'd0);
    q.delete();
    m_bit = 0;
    m_frm = 0;
    m_ferr = 0;
    check_cnt("midrst");
    tick();
    tick();
    rst = 1'b0;
    tick();
    send(rnd_vec(20));
    wait_done("after_rst", 1'b0);
    check_cnt("after_rst");

    // Statistics clear coincident with the last handshake.
    send(rnd_vec(50));
    n = 0;
    while (q.size() > 1 && n < 2000) begin
      tick();
      n++;
    end
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    m_bit = 0;
    m_frm = 0;
    m_ferr = 0;
    chk("clr_res_ready", 64'(res_ready), 64'd1);
    chk("clr_dout_valid", 64'(dout_valid), 64'd0);
    wait_done("clr", 1'b0);
    check_cnt("clr");

    // Bit-error counter saturation.
    force dut.bit_err_q = 32'hFFFF_FFFE;
    tick();
    release dut.bit_err_q;
    tick();
    m_bit = 64'hFFFF_FFFE;
    chk("preload_bit_err_cnt", 64'(bit_err_cnt), 64'(m_bit));
    send('1);
    wait_done("sat", 1'b0);
    check_cnt("sat");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
